// File: rtl/i2c_slave_cmd_engine_if.sv
// Command, upload and core-register buses between the CDC/I2C core side and the command engine.
// slave modport is the engine; master modport is whatever drives commands and consumes uploads.
interface i2c_slave_cmd_engine_if;
    logic [7:0]  cmd_type;
    logic [15:0] cmd_length;
    logic [7:0]  cmd_data;
    logic [15:0] cmd_data_index;
    logic        cmd_start;
    logic        cmd_data_valid;
    logic        cmd_done;
    logic        cmd_ready;
    logic        cmd_error;

    logic        upload_active;
    logic        upload_req;
    logic [7:0]  upload_data;
    logic [7:0]  upload_source;
    logic        upload_valid;
    logic        upload_ready;

    logic [6:0]  slave_addr;
    logic [7:0]  core_addr;
    logic [7:0]  core_wdata;
    logic        core_wr_en;
    logic [7:0]  core_rdata;

    modport slave (
        input  cmd_type, cmd_length, cmd_data, cmd_data_index,
        input  cmd_start, cmd_data_valid, cmd_done,
        output cmd_ready, cmd_error,
        output upload_active, upload_req, upload_data, upload_source, upload_valid,
        input  upload_ready,
        output slave_addr,
        input  core_addr, core_wdata, core_wr_en,
        output core_rdata
    );

    modport master (
        output cmd_type, cmd_length, cmd_data, cmd_data_index,
        output cmd_start, cmd_data_valid, cmd_done,
        input  cmd_ready, cmd_error,
        input  upload_active, upload_req, upload_data, upload_source, upload_valid,
        output upload_ready,
        input  slave_addr,
        output core_addr, core_wdata, core_wr_en,
        input  core_rdata
    );
endinterface

// File: rtl/i2c_slave_cmd_engine.sv
// Command engine: captures payloads, runs set-address/write/read-upload on a register file shared with the I2C core.
// Decode one cycle after cmd_done, one byte per cycle; core writes stall handler writes, upload_ready low holds UPLOAD.
module i2c_slave_cmd_engine #(
    parameter int         NUM_REGS           = 16,
    parameter int         MAX_PAYLOAD        = 32,
    parameter logic [6:0] DEFAULT_SLAVE_ADDR = 7'h24
) (
    input logic                  clk,
    input logic                  rst,
    i2c_slave_cmd_engine_if.slave bus
);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int BW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int RW = $clog2(MAX_PAYLOAD + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CAPTURE  = 3'd1;
    localparam logic [2:0] S_DECODE   = 3'd2;
    localparam logic [2:0] S_SET_ADDR = 3'd3;
    localparam logic [2:0] S_WRITE    = 3'd4;
    localparam logic [2:0] S_UPLOAD   = 3'd5;
    localparam logic [2:0] S_FINISH   = 3'd6;

    logic [2:0]    state;
    logic [7:0]    regs    [1<<AW];
    logic [7:0]    pay_buf [1<<BW];
    logic [RW-1:0] rx_cnt;
    logic          overflow;
    logic          err_flag;
    logic [7:0]    start_addr;
    logic [7:0]    num_bytes;
    logic [7:0]    ptr;
    logic [6:0]    slave_addr_r;

    function automatic logic mapped(input logic [7:0] a);
        return {1'b0, a} < 9'(NUM_REGS);
    endfunction

    logic [7:0]    tgt;
    logic [BW-1:0] widx;
    logic          capturing;
    logic          idx_ok;
    logic [RW-1:0] idx1;
    logic [RW-1:0] rx_base;
    logic          core_wr_ok;
    logic          hdl_wr;
    logic [15:0]   avail;
    logic [7:0]    len_b;
    logic [7:0]    n_wr;

    always_comb begin
        tgt        = start_addr + ptr;
        widx       = BW'(ptr) + BW'(2);
        capturing  = (state == S_IDLE && bus.cmd_start) || state == S_CAPTURE;
        idx_ok     = bus.cmd_data_index < 16'(MAX_PAYLOAD);
        idx1       = RW'(bus.cmd_data_index[BW-1:0]) + RW'(1);
        rx_base    = (state == S_IDLE) ? '0 : rx_cnt;
        core_wr_ok = bus.core_wr_en && mapped(bus.core_addr);
        hdl_wr     = state == S_WRITE && !bus.core_wr_en && mapped(tgt);
        // Write length is clamped to the data bytes actually received behind start/len.
        len_b      = pay_buf[1];
        avail      = 16'(rx_cnt) - 16'd2;
        n_wr       = (16'(len_b) < avail) ? len_b : avail[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            rx_cnt       <= '0;
            overflow     <= 1'b0;
            err_flag     <= 1'b0;
            start_addr   <= 8'h00;
            num_bytes    <= 8'h00;
            ptr          <= 8'h00;
            slave_addr_r <= DEFAULT_SLAVE_ADDR;
            for (int i = 0; i < (1<<AW); i++) regs[i] <= 8'h00;
            for (int i = 0; i < (1<<BW); i++) pay_buf[i] <= 8'h00;
        end else begin
            if (state == S_IDLE) begin
                rx_cnt   <= '0;
                overflow <= 1'b0;
                err_flag <= 1'b0;
            end
            if (capturing && bus.cmd_data_valid) begin
                if (idx_ok) begin
                    pay_buf[bus.cmd_data_index[BW-1:0]] <= bus.cmd_data;
                    if (idx1 > rx_base) rx_cnt <= idx1;
                end else begin
                    overflow <= 1'b1;
                end
            end

            if (hdl_wr)
                regs[tgt[AW-1:0]] <= pay_buf[widx];
            else if (core_wr_ok)
                regs[bus.core_addr[AW-1:0]] <= bus.core_wdata;

            case (state)
                S_IDLE: begin
                    if (bus.cmd_start) state <= bus.cmd_done ? S_DECODE : S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (bus.cmd_done) state <= S_DECODE;
                end
                S_DECODE: begin
                    ptr        <= 8'h00;
                    start_addr <= pay_buf[0];
                    state      <= S_FINISH;
                    case (bus.cmd_type)
                        8'h14: begin
                            if (rx_cnt >= RW'(1)) state <= S_SET_ADDR;
                            else                  err_flag <= 1'b1;
                        end
                        8'h15: begin
                            if (rx_cnt >= RW'(2)) begin
                                num_bytes <= n_wr;
                                if (n_wr != 8'h00) state <= S_WRITE;
                            end else begin
                                err_flag <= 1'b1;
                            end
                        end
                        8'h16: begin
                            if (rx_cnt >= RW'(2)) begin
                                num_bytes <= len_b;
                                if (len_b != 8'h00) state <= S_UPLOAD;
                            end else begin
                                err_flag <= 1'b1;
                            end
                        end
                        default: err_flag <= 1'b1;
                    endcase
                end
                S_SET_ADDR: begin
                    slave_addr_r <= pay_buf[0][6:0];
                    state        <= S_FINISH;
                end
                S_WRITE: begin
                    if (!bus.core_wr_en) begin
                        ptr <= ptr + 8'd1;
                        if (ptr == num_bytes - 8'd1) state <= S_FINISH;
                    end
                end
                S_UPLOAD: begin
                    if (bus.upload_ready) begin
                        ptr <= ptr + 8'd1;
                        if (ptr == num_bytes - 8'd1) state <= S_FINISH;
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready     = state == S_IDLE;
    assign bus.cmd_error     = state == S_FINISH && err_flag;
    assign bus.upload_active = state == S_UPLOAD;
    assign bus.upload_req    = state == S_UPLOAD;
    assign bus.upload_valid  = state == S_UPLOAD && bus.upload_ready;
    assign bus.upload_source = 8'h16;
    assign bus.upload_data   = mapped(tgt) ? regs[tgt[AW-1:0]] : 8'h00;
    assign bus.core_rdata    = mapped(bus.core_addr) ? regs[bus.core_addr[AW-1:0]] : 8'h00;
    assign bus.slave_addr    = slave_addr_r;

    wire unused_ok = ^{bus.cmd_length, overflow};
endmodule
